retire_pair_sync: RTL and testbench

RETIRE_PAIR_SYNC -- requirements
Module: retire_pair_sync

---
 rtl/retire_pkg.sv | 27 ++
 rtl/retire_pair_sync_if.sv | 33 +++
 rtl/retire_fifo.sv | 71 +++++++
 rtl/retire_pair_sync.sv | 104 ++++++++++
 tb/tb_retire_pair_sync.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/retire_pkg.sv
// Shared types and widths for the retirement pairing block.
// Holds the retirement record layout emitted by each lockstep core copy.
package retire_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned MASK_W = 4;

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   reg_rs1;
    logic [XLEN-1:0]   reg_rs2;
    logic [XLEN-1:0]   reg_rd;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_r_data;
    logic [MASK_W-1:0] mem_r_mask;
    logic [XLEN-1:0]   mem_w_data;
    logic [MASK_W-1:0] mem_w_mask;
    logic [XLEN-1:0]   new_pc;
  } retire_rec_t;

  localparam int unsigned RecW = $bits(retire_rec_t);

endpackage

// File: rtl/retire_pair_sync_if.sv
// Bus bundle for retire_pair_sync.
//   valid_x_i / rec_x_i : retirement stream from core copy x
//   retire_o            : paired record presented this cycle
//   rec_x_o             : registered paired records
//   full_x_o            : side x FIFO holds DEPTH entries
//   overflow_o/desync_o : sticky error flags
// slave is the pairing block, master is the retirement source / checker side.
interface retire_pair_sync_if;
  import retire_pkg::*;

  logic        valid_1_i;
  retire_rec_t rec_1_i;
  logic        valid_2_i;
  retire_rec_t rec_2_i;
  logic        retire_o;
  retire_rec_t rec_1_o;
  retire_rec_t rec_2_o;
  logic        full_1_o;
  logic        full_2_o;
  logic        overflow_o;
  logic        desync_o;

  modport slave (
    input  valid_1_i, rec_1_i, valid_2_i, rec_2_i,
    output retire_o, rec_1_o, rec_2_o, full_1_o, full_2_o, overflow_o, desync_o
  );

  modport master (
    output valid_1_i, rec_1_i, valid_2_i, rec_2_i,
    input  retire_o, rec_1_o, rec_2_o, full_1_o, full_2_o, overflow_o, desync_o
  );

endinterface

// File: rtl/retire_fifo.sv
// Per-side retirement record FIFO.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write request and record
//   pop_i         : read request (caller guarantees the FIFO is nonempty)
//   head_o        : oldest record
//   count_o       : occupancy, 0..DEPTH
//   full_o        : count_o == DEPTH
//   drop_o        : push rejected this cycle (full and no pop)
module retire_fifo import retire_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  retire_rec_t              data_i,
  input  logic                     pop_i,
  output retire_rec_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     drop_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push;
  retire_rec_t     mem_q [DEPTH];

  always_comb begin
    full_o  = (count_q == (PtrW + 1)'(DEPTH));
    // A full FIFO still accepts a push when it pops at the same edge.
    do_push = push_i && (!full_o || pop_i);
    drop_o  = push_i && full_o && !pop_i;

    // Pointers are log2(DEPTH) wide so they wrap naturally.
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    unique case ({do_push, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/retire_pair_sync.sv
// Pairs retirement records from two lockstep core copies.
//   clk_i, rst_ni : clock, async active-low reset
//   bus_io        : retire_pair_sync_if.slave (input streams, paired outputs, flags)
// Each side buffers into its own FIFO; a pair is popped when both sides hold a
// record and no error flag is set. A skew counter detects one side running
// ahead for TIMEOUT cycles; a dropped record or timeout halts pairing until reset.
module retire_pair_sync import retire_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  retire_pair_sync_if.slave   bus_io
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned SkewW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0]  count_1, count_2;
  retire_rec_t      head_1, head_2;
  logic             full_1, full_2;
  logic             drop_1, drop_2;
  logic             pop;
  logic             nonempty_1, nonempty_2;

  logic [SkewW-1:0] skew_q, skew_d;
  logic             retire_q, retire_d;
  logic             overflow_q, overflow_d;
  logic             desync_q, desync_d;
  retire_rec_t      rec_1_q, rec_1_d;
  retire_rec_t      rec_2_q, rec_2_d;

  retire_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus_io.valid_1_i),
    .data_i  (bus_io.rec_1_i),
    .pop_i   (pop),
    .head_o  (head_1),
    .count_o (count_1),
    .full_o  (full_1),
    .drop_o  (drop_1)
  );

  retire_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus_io.valid_2_i),
    .data_i  (bus_io.rec_2_i),
    .pop_i   (pop),
    .head_o  (head_2),
    .count_o (count_2),
    .full_o  (full_2),
    .drop_o  (drop_2)
  );

  always_comb begin
    nonempty_1 = (count_1 != '0);
    nonempty_2 = (count_2 != '0);
    // Pop decision uses pre-edge counts only, so there is no bypass path.
    pop = nonempty_1 && nonempty_2 && !overflow_q && !desync_q;

    skew_d = skew_q;
    if (pop || (!nonempty_1 && !nonempty_2)) begin
      skew_d = '0;
    end else if ((nonempty_1 != nonempty_2) && (skew_q != SkewW'(TIMEOUT))) begin
      // Saturate so the counter cannot wrap back below TIMEOUT.
      skew_d = skew_q + 1'b1;
    end

    desync_d   = desync_q || (skew_d == SkewW'(TIMEOUT));
    overflow_d = overflow_q || drop_1 || drop_2;
    retire_d   = pop;
    rec_1_d    = pop ? head_1 : rec_1_q;
    rec_2_d    = pop ? head_2 : rec_2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skew_q     <= '0;
      retire_q   <= 1'b0;
      overflow_q <= 1'b0;
      desync_q   <= 1'b0;
      rec_1_q    <= '0;
      rec_2_q    <= '0;
    end else begin
      skew_q     <= skew_d;
      retire_q   <= retire_d;
      overflow_q <= overflow_d;
      desync_q   <= desync_d;
      rec_1_q    <= rec_1_d;
      rec_2_q    <= rec_2_d;
    end
  end

  assign bus_io.retire_o   = retire_q;
  assign bus_io.rec_1_o    = rec_1_q;
  assign bus_io.rec_2_o    = rec_2_q;
  assign bus_io.full_1_o   = full_1;
  assign bus_io.full_2_o   = full_2;
  assign bus_io.overflow_o = overflow_q;
  assign bus_io.desync_o   = desync_q;

endmodule

// File: tb/tb_retire_pair_sync.sv
// Bench for retire_pair_sync: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model.
module tb_retire_pair_sync;
  import retire_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  retire_pair_sync_if bus_if ();

  retire_pair_sync #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  retire_rec_t q1[$];
  retire_rec_t q2[$];
  bit          m_ov, m_ds, m_ret;
  int          m_skew;
  retire_rec_t m_r1, m_r2;

  retire_rec_t zero_rec;

  task automatic check_eq(input string tag, input logic [RecW-1:0] got,
                          input logic [RecW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic retire_rec_t rand_rec();
    retire_rec_t r;
    r.instr      = $urandom;
    r.rd         = 5'($urandom);
    r.rs1        = 5'($urandom);
    r.rs2        = 5'($urandom);
    r.reg_rs1    = $urandom;
    r.reg_rs2    = $urandom;
    r.reg_rd     = $urandom;
    r.mem_addr   = $urandom;
    r.mem_r_data = $urandom;
    r.mem_r_mask = 4'($urandom);
    r.mem_w_data = $urandom;
    r.mem_w_mask = 4'($urandom);
    r.new_pc     = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    q1.delete();
    q2.delete();
    m_ov   = 0;
    m_ds   = 0;
    m_ret  = 0;
    m_skew = 0;
    m_r1   = '0;
    m_r2   = '0;
  endtask

  // One rising edge of the pairing rules, evaluated on pre-edge state.
  task automatic model_edge(input bit v1, input retire_rec_t r1,
                            input bit v2, input retire_rec_t r2);
    int  s1 = q1.size();
    int  s2 = q2.size();
    bit  pop = (s1 > 0) && (s2 > 0) && !m_ov && !m_ds;
    m_ret = pop;
    if (pop) begin
      m_r1 = q1.pop_front();
      m_r2 = q2.pop_front();
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(r1);
      else m_ov = 1;
    end
    if (v2) begin
      if (q2.size() < DEPTH) q2.push_back(r2);
      else m_ov = 1;
    end
    if (pop || (s1 == 0 && s2 == 0)) m_skew = 0;
    else if (((s1 > 0) != (s2 > 0)) && m_skew < TIMEOUT) m_skew++;
    if (m_skew >= TIMEOUT) m_ds = 1;
  endtask

  task automatic check_outputs();
    check_eq("retire", RecW'(bus_if.retire_o), RecW'(m_ret));
    check_eq("rec_1", bus_if.rec_1_o, m_r1);
    check_eq("rec_2", bus_if.rec_2_o, m_r2);
    check_eq("full_1", RecW'(bus_if.full_1_o), RecW'(q1.size() == DEPTH));
    check_eq("full_2", RecW'(bus_if.full_2_o), RecW'(q2.size() == DEPTH));
    check_eq("overflow", RecW'(bus_if.overflow_o), RecW'(m_ov));
    check_eq("desync", RecW'(bus_if.desync_o), RecW'(m_ds));
  endtask

  task automatic step(input bit v1, input retire_rec_t r1,
                      input bit v2, input retire_rec_t r2);
    bus_if.valid_1_i = v1;
    bus_if.rec_1_i   = r1;
    bus_if.valid_2_i = v2;
    bus_if.rec_2_i   = r2;
    @(posedge clk_i);
    model_edge(v1, r1, v2, r2);
    #1;
    bus_if.valid_1_i = 1'b0;
    bus_if.valid_2_i = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, zero_rec, 1'b0, zero_rec);
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
  endtask

  initial begin
    retire_rec_t a;
    retire_rec_t b;
    int          stuck;
    zero_rec = '0;
    bus_if.valid_1_i = 1'b0;
    bus_if.valid_2_i = 1'b0;
    bus_if.rec_1_i   = '0;
    bus_if.rec_2_i   = '0;
    model_clear();

    #1;
    do_reset();
    idle(1);

    // Lockstep: four pairs, each presented one cycle after its push.
    for (int i = 0; i < 4; i++) begin
      a = rand_rec();
      step(1'b1, a, 1'b1, a);
    end
    idle(2);

    // Skew of five cycles, still inside the timeout.
    a = rand_rec();
    b = rand_rec();
    step(1'b1, a, 1'b0, zero_rec);
    idle(4);
    step(1'b0, zero_rec, 1'b1, b);
    idle(2);

    // Overflow: five pushes on side 1 only.
    for (int i = 0; i < 5; i++) step(1'b1, rand_rec(), 1'b0, zero_rec);
    idle(2);
    do_reset();

    // Timeout: one record on side 2, side 1 idle; later side-1 push must not pair.
    step(1'b0, zero_rec, 1'b1, rand_rec());
    idle(18);
    step(1'b1, rand_rec(), 1'b0, zero_rec);
    idle(2);
    do_reset();

    // Full side 1 accepts a push at the edge where it pops.
    for (int i = 0; i < 4; i++) step(1'b1, rand_rec(), 1'b0, zero_rec);
    step(1'b0, zero_rec, 1'b1, rand_rec());
    step(1'b1, rand_rec(), 1'b0, zero_rec);
    for (int i = 0; i < 4; i++) step(1'b0, zero_rec, 1'b1, rand_rec());
    idle(2);

    // Reset mid-stream discards buffered records.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_rec(), 1'b0, zero_rec);
    do_reset();
    idle(1);
    a = rand_rec();
    b = rand_rec();
    step(1'b1, a, 1'b1, b);
    idle(2);

    // Random traffic; reset a few cycles after pairing halts.
    stuck = 0;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 50), rand_rec(), ($urandom_range(0, 99) < 50), rand_rec());
      if (m_ov || m_ds) stuck++;
      if (stuck > 3) begin
        do_reset();
        stuck = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
